// File: rtl/decodificador_varredura_if.sv
// Bus bundle for decodificador_varredura: control inputs and registered outputs.
// The mascara signal exists only when DECOD_MASCARA_EN is defined.
interface decodificador_varredura_if #(
    parameter int N = 3
);
    localparam int W = 1 << N;

    logic         en_i;
    logic         modo_i;
    logic [N-1:0] a_i;
    logic [W-1:0] d_o;
    logic [N-1:0] idx_o;
    logic         wrap_o;
`ifdef DECOD_MASCARA_EN
    logic [W-1:0] mascara_i;

    modport master (output en_i, modo_i, a_i, mascara_i, input d_o, idx_o, wrap_o);
    modport slave  (input en_i, modo_i, a_i, mascara_i, output d_o, idx_o, wrap_o);
`else
    modport master (output en_i, modo_i, a_i, input d_o, idx_o, wrap_o);
    modport slave  (input en_i, modo_i, a_i, output d_o, idx_o, wrap_o);
`endif
endinterface

// File: rtl/decodificador_varredura.sv
// Registered 1-of-2**N decoder with direct and scan modes.
// Scan mode steps an index through the outputs, dwelling DIV clocks on each,
// and pulses wrap when the sweep returns to (or past) its start.
// Optional feature macro: DECOD_MASCARA_EN adds a per-output mask that both
// gates d and makes the scan skip masked-off indices.
module decodificador_varredura #(
    parameter int N          = 3,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    decodificador_varredura_if.slave   bus
);
    localparam int           W       = 1 << N;
    localparam int           CW      = $clog2(DIV) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [W-1:0] ONE     = W'(1);
    // XOR pattern applied to every d value so the register itself holds the
    // port polarity (reset value included).
    localparam logic [W-1:0] INV     = {W{ACTIVE_LOW}};

    generate
        if (N < 1 || N > 6) begin : g_bad_n
            $error("decodificador_varredura: N must be in 1..6");
        end
        if (DIV < 1) begin : g_bad_div
            $error("decodificador_varredura: DIV must be >= 1");
        end
    endgenerate

    logic [W-1:0]  d_q, d_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;
    logic [W-1:0]  mask;
    logic [N-1:0]  nxt;

`ifdef DECOD_MASCARA_EN
    logic [N-1:0]  cand;

    assign mask = bus.mascara_i;

    // Circular search for the first enabled index after idx; walking the
    // offsets from farthest to nearest lets the nearest hit win. Offset W
    // lands on idx itself, covering the single-bit mask case.
    always_comb begin
        nxt  = idx_q;
        cand = '0;
        for (int k = W; k >= 1; k--) begin
            cand = N'(int'(idx_q) + k);
            if (mask[cand]) nxt = cand;
        end
    end
`else
    assign mask = '1;

    // Without a mask the next index is a plain modulo-2**N increment.
    always_comb begin
        nxt = idx_q + N'(1);
    end
`endif

    // Next-state: blank/hold when disabled, decode a in direct mode,
    // dwell-then-advance in scan mode.
    always_comb begin
        d_d    = INV;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (bus.en_i) begin
            if (!bus.modo_i) begin
                d_d   = ((ONE << bus.a_i) & mask) ^ INV;
                idx_d = bus.a_i;
                cnt_d = '0;
            end else if (mask != '0) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                    d_d   = ((ONE << idx_q) & mask) ^ INV;
                end else begin
                    cnt_d  = '0;
                    idx_d  = nxt;
                    d_d    = ((ONE << nxt) & mask) ^ INV;
                    wrap_d = (nxt <= idx_q);
                end
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_q    <= INV;
            idx_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            d_q    <= d_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.d_o    = d_q;
    assign bus.idx_o  = idx_q;
    assign bus.wrap_o = wrap_q;
endmodule

// File: tb/tb_decodificador_varredura.sv
// Scoreboard bench for decodificador_varredura: the stimulus process updates a
// behavioural model and queues the expected outputs for each edge; a monitor
// pops one entry after every edge and compares.
module tb_decodificador_varredura;
    localparam int N          = 3;
    localparam int DIV        = 4;
    localparam bit ACTIVE_LOW = 0;
    localparam int W          = 1 << N;

    typedef struct {
        logic [W-1:0] d;
        logic [N-1:0] idx;
        logic         wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   checks = 0;
    int   errs   = 0;
    int   cyc    = 0;
    bit   done   = 1'b0;

    // behavioural model state
    int m_idx = 0;
    int m_cnt = 0;

    decodificador_varredura_if #(.N(N)) bus ();

    decodificador_varredura #(.N(N), .DIV(DIV), .ACTIVE_LOW(ACTIVE_LOW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] bit_at(input int i);
        logic [W-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Apply inputs for the coming edge, predict its outcome, wait past the edge.
    task automatic drive(input bit r, input bit e, input bit m, input int a, input logic [W-1:0] msk);
        exp_t x;
        int   nx;
        rst         = r;
        bus.en_i    = e;
        bus.modo_i  = m;
        bus.a_i     = N'(a);
`ifdef DECOD_MASCARA_EN
        bus.mascara_i = msk;
`else
        msk = '1;
`endif
        x.wrap = 1'b0;
        x.d    = '0;
        if (r) begin
            m_idx = 0;
            m_cnt = 0;
        end else if (!e) begin
            // blanked, index and dwell frozen
        end else if (!m) begin
            m_idx = a;
            m_cnt = 0;
            x.d   = bit_at(a) & msk;
        end else if (msk == '0) begin
            // nothing selectable: blank and hold
        end else if (m_cnt < DIV - 1) begin
            m_cnt = m_cnt + 1;
            x.d   = bit_at(m_idx) & msk;
        end else begin
            nx = (m_idx + 1) % W;
            while (!msk[nx]) nx = (nx + 1) % W;
            x.wrap = (nx <= m_idx);
            m_idx  = nx;
            m_cnt  = 0;
            x.d    = bit_at(nx) & msk;
        end
        if (ACTIVE_LOW) x.d = ~x.d;
        x.idx = N'(m_idx);
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expectation per edge, compared 1 time unit after it.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() != 0) begin
                x = q.pop_front();
                checks += 3;
                if (bus.d_o !== x.d) begin
                    errs++;
                    $display("FAIL d cyc=%0d got=%h exp=%h", cyc, bus.d_o, x.d);
                end
                if (bus.idx_o !== x.idx) begin
                    errs++;
                    $display("FAIL idx cyc=%0d got=%0d exp=%0d", cyc, bus.idx_o, x.idx);
                end
                if (bus.wrap_o !== x.wrap) begin
                    errs++;
                    $display("FAIL wrap cyc=%0d got=%b exp=%b", cyc, bus.wrap_o, x.wrap);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] all1;
        logic [W-1:0] rm;
        all1 = '1;
        bus.en_i   = 1'b0;
        bus.modo_i = 1'b0;
        bus.a_i    = '0;
`ifdef DECOD_MASCARA_EN
        bus.mascara_i = '1;
`endif
        // reset held two clocks
        repeat (2) drive(1, 0, 0, 0, all1);
        // direct a=5, then disable
        drive(0, 1, 0, 5, all1);
        repeat (2) drive(0, 0, 0, 3, all1);
        // full sweep from idx 0, over one wrap
        drive(0, 1, 0, 0, all1);
        repeat (40) drive(0, 1, 1, 0, all1);
        // pause at cnt=2 for 5 clocks, then resume
        drive(0, 1, 0, 3, all1);
        repeat (2) drive(0, 1, 1, 0, all1);
        repeat (5) drive(0, 0, 1, 0, all1);
        repeat (10) drive(0, 1, 1, 0, all1);
        // reset mid-scan at idx 6, release straight into scan
        drive(0, 1, 0, 6, all1);
        repeat (2) drive(0, 1, 1, 0, all1);
        drive(1, 1, 1, 0, all1);
        repeat (8) drive(0, 1, 1, 0, all1);
        // last index wraps: direct 7 then scan
        drive(0, 1, 0, 7, all1);
        repeat (6) drive(0, 1, 1, 2, all1);
`ifdef DECOD_MASCARA_EN
        // sparse mask 1,4,7 then an empty mask, then a single-bit mask
        drive(0, 1, 0, 1, 8'b10010010);
        repeat (30) drive(0, 1, 1, 0, 8'b10010010);
        repeat (4) drive(0, 1, 1, 0, 8'h00);
        repeat (12) drive(0, 1, 1, 0, 8'b00010000);
`endif
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rm = W'($urandom);
            if ($urandom_range(0, 9) == 0) rm = '0;
            if ($urandom_range(0, 2) == 0) rm = '1;
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 3) != 0), int'($urandom_range(0, W - 1)), rm);
        end
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Hard bound on run time in case the stimulus ever stalls.
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout cyc=%0d exp=finished", cyc);
            $fatal(1, "timeout");
        end
    end
endmodule
